display_scan_controller: RTL and testbench

//  Time-multiplexes the 4-digit 7-segment display. Drives the active-low
//  one-hot digit select plus the value/sign/format fields consumed by the

---
 rtl/display_pkg.sv | 29 ++
 rtl/display_scan_controller_scan_timer.sv | 37 +++
 rtl/display_scan_controller.sv | 166 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the 4-digit display scan controller.
//   Provides the scan state enum, the blank anode code, the digit count
//   and a helper that maps a digit slot to its active-low anode code.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SLOT_W     = 2;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        DWELL = 1'b1
    } scan_state_t;

    // Exactly one anode pulled low per slot; slot 0 is the rightmost digit.
    function automatic logic [3:0] anode_code(input logic [SLOT_W-1:0] slot);
        logic [3:0] code;
        case (slot)
            2'd0:    code = 4'b1110;
            2'd1:    code = 4'b1101;
            2'd2:    code = 4'b1011;
            default: code = 4'b0111;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// scan_timer
//   Free-running phase counter for the scan FSM. Counts 0..limit and flags
//   the terminal count; the owner clears it to start a new phase.
// Ports
//   clk       in   1      system clock
//   reset_n   in   1      synchronous reset, active-low
//   clear     in   1      restart counting from 0 on the next edge
//   limit     in   WIDTH  last count value of the current phase
//   terminal  out  1      high while count equals limit
module scan_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    // Counter restarts on reset or when the owner ends the current phase.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    // Terminal flag is combinational so the FSM can switch state on the
    // same cycle the last count is presented.
    always_comb begin
        terminal = (count == limit);
    end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexes a 4-digit 7-segment display. Each digit slot gets a
//   blanking gap (all anodes off) followed by a dwell with its anode lit.
//   New display data arrives over valid/ready, waits in a pending register,
//   and is committed only at the end of a frame so a frame never tears.
// Ports
//   clk            in   1  system clock
//   reset_n        in   1  synchronous reset, active-low
//   enable         in   1  1 = scan, 0 = blank and hold in slot 0
//   in_valid       in   1  new display data offered
//   in_ready       out  1  no update pending, data can be accepted
//   in_value       in   6  magnitude to display
//   in_negative    in   1  minus sign request
//   in_is_dec      in   1  1 = decimal, 0 = hex
//   digit          out  4  active-low anode select
//   display_value  out  6  committed magnitude
//   show_negative  out  1  committed sign
//   is_dec         out  1  committed format
//   frame_done     out  1  pulse on the last dwell cycle of slot 3
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_value,
    input  logic       in_negative,
    input  logic       in_is_dec,
    output logic [3:0] digit,
    output logic [5:0] display_value,
    output logic       show_negative,
    output logic       is_dec,
    output logic       frame_done
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DWELL_LAST = TIMER_W'(DWELL_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(NUM_DIGITS - 1);

    scan_state_t       state_q;
    scan_state_t       state_d;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    logic               timer_done;
    logic               timer_clear;
    logic [TIMER_W-1:0] timer_limit;

    logic       pending_q;
    logic [5:0] pend_value_q;
    logic       pend_negative_q;
    logic       pend_is_dec_q;
    logic       accept;
    logic       commit;

    // Phase length depends on which half of the slot we are in. Disabling
    // the scanner parks the timer at 0 so re-enabling yields a full blank.
    always_comb begin
        timer_limit = (state_q == DWELL) ? DWELL_LAST : BLANK_LAST;
        timer_clear = !enable || timer_done;
    end

    scan_timer #(
        .WIDTH(TIMER_W)
    ) u_scan_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .limit   (timer_limit),
        .terminal(timer_done)
    );

    // Scan state and slot registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= BLANK;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state logic: blank gap, then dwell, then advance to the next slot.
    // The slot counter is exactly SLOT_W bits wide, so slot 3 wraps to 0.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (!enable) begin
            state_d = BLANK;
            slot_d  = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (timer_done) begin
                        state_d = DWELL;
                    end
                end
                DWELL: begin
                    if (timer_done) begin
                        state_d = BLANK;
                        slot_d  = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = BLANK;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // Decoded outputs: anodes only ever driven during a dwell, and the frame
    // ends on the final dwell cycle of the last slot.
    always_comb begin
        digit      = (state_q == DWELL) ? anode_code(slot_q) : ANODE_OFF;
        frame_done = (state_q == DWELL) && (slot_q == LAST_SLOT) && timer_done;
        in_ready   = !pending_q;
        accept     = in_valid && !pending_q;
        commit     = frame_done && pending_q;
    end

    // Pending holding register. A transfer and a commit can never coincide
    // because a transfer requires the pending slot to be empty, so data
    // accepted on a frame_done cycle waits for the following frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q       <= 1'b0;
            pend_value_q    <= '0;
            pend_negative_q <= 1'b0;
            pend_is_dec_q   <= 1'b0;
        end else begin
            if (commit) begin
                pending_q <= 1'b0;
            end
            if (accept) begin
                pending_q       <= 1'b1;
                pend_value_q    <= in_value;
                pend_negative_q <= in_negative;
                pend_is_dec_q   <= in_is_dec;
            end
        end
    end

    // Committed display fields only change at a frame boundary.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            display_value <= '0;
            show_negative <= 1'b0;
            is_dec        <= 1'b1;
        end else if (commit) begin
            display_value <= pend_value_q;
            show_negative <= pend_negative_q;
            is_dec        <= pend_is_dec_q;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//   Self-checking bench for display_scan_controller with DWELL=4, BLANK=2.
//   A cycle-count reference model predicts every output per cycle; the
//   predictions are queued and a separate monitor compares them.
module tb_display_scan_controller;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int SLOT_LEN  = DW + BL;
    localparam int FRAME_LEN = 4 * SLOT_LEN;

    typedef struct packed {
        logic [3:0] digit;
        logic       frame_done;
        logic       in_ready;
        logic [5:0] value;
        logic       negative;
        logic       dec;
    } expect_t;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_value;
    logic       in_negative;
    logic       in_is_dec;
    logic [3:0] digit;
    logic [5:0] display_value;
    logic       show_negative;
    logic       is_dec;
    logic       frame_done;

    expect_t exp_q[$];

    int tests_run;
    int tests_failed;

    int         m_cyc;
    logic       m_pending;
    logic [5:0] m_pend_value;
    logic       m_pend_neg;
    logic       m_pend_dec;
    logic [5:0] m_value;
    logic       m_neg;
    logic       m_dec;
    logic       last_fd;
    int         last_pos;

    display_scan_controller #(
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_value     (in_value),
        .in_negative  (in_negative),
        .in_is_dec    (in_is_dec),
        .digit        (digit),
        .display_value(display_value),
        .show_negative(show_negative),
        .is_dec       (is_dec),
        .frame_done   (frame_done)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference digit for a position within the frame: blank gap first,
    // then the slot's single active-low anode.
    function automatic logic [3:0] refDigit(input int pos);
        int slot;
        int offs;
        logic [3:0] d;
        slot = pos / SLOT_LEN;
        offs = pos % SLOT_LEN;
        d = 4'b1111;
        if (offs >= BL) begin
            d[slot] = 1'b0;
        end
        return d;
    endfunction

    function automatic expect_t refOutputs();
        expect_t e;
        int pos;
        pos          = m_cyc % FRAME_LEN;
        e.digit      = refDigit(pos);
        e.frame_done = (pos == FRAME_LEN - 1);
        e.in_ready   = !m_pending;
        e.value      = m_value;
        e.negative   = m_neg;
        e.dec        = m_dec;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, required);
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge, then
    // queue the outputs expected for the cycle that follows.
    task automatic stepCycle();
        expect_t e;
        logic fd_now;
        logic take;
        @(posedge clk);
        if (!reset_n) begin
            m_cyc     = 0;
            m_pending = 1'b0;
            m_value   = 6'd0;
            m_neg     = 1'b0;
            m_dec     = 1'b1;
        end else begin
            fd_now = ((m_cyc % FRAME_LEN) == FRAME_LEN - 1);
            take   = in_valid && !m_pending;
            if (fd_now && m_pending) begin
                m_value   = m_pend_value;
                m_neg     = m_pend_neg;
                m_dec     = m_pend_dec;
                m_pending = 1'b0;
            end
            if (take) begin
                m_pending    = 1'b1;
                m_pend_value = in_value;
                m_pend_neg   = in_negative;
                m_pend_dec   = in_is_dec;
            end
            m_cyc = enable ? m_cyc + 1 : 0;
        end
        #1;
        e = refOutputs();
        exp_q.push_back(e);
        last_fd  = e.frame_done;
        last_pos = m_cyc % FRAME_LEN;
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic v,
                                 input logic [5:0] val, input logic neg, input logic dec,
                                 input int cycles);
        for (int i = 0; i < cycles; i++) begin
            reset_n     = r;
            enable      = en;
            in_valid    = v;
            in_value    = val;
            in_negative = neg;
            in_is_dec   = dec;
            stepCycle();
        end
    endtask

    // Idle-scan until the presented cycle is the frame's last one (or a
    // given frame position); an exhausted budget counts as a failure.
    task automatic waitForPos(input int pos, input string name);
        int budget;
        budget = 0;
        while (last_pos != pos && budget < 2 * FRAME_LEN) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1);
            budget++;
        end
        tests_run++;
        if (last_pos != pos) begin
            tests_failed++;
            $display("[TB] FAIL %s: frame position %0d never reached, wanted %0d", name, last_pos, pos);
        end
    endtask

    // Monitor: compare every queued prediction against the DUT mid-cycle.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("digit",         32'(digit),         32'(e.digit));
                checkOutput("frame_done",    32'(frame_done),    32'(e.frame_done));
                checkOutput("in_ready",      32'(in_ready),      32'(e.in_ready));
                checkOutput("display_value", 32'(display_value), 32'(e.value));
                checkOutput("show_negative", 32'(show_negative), 32'(e.negative));
                checkOutput("is_dec",        32'(is_dec),        32'(e.dec));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_cyc        = 0;
        m_pending    = 1'b0;
        m_pend_value = 6'd0;
        m_pend_neg   = 1'b0;
        m_pend_dec   = 1'b0;
        m_value      = 6'd0;
        m_neg        = 1'b0;
        m_dec        = 1'b1;
        last_fd      = 1'b0;
        last_pos     = 0;

        reset_n     = 1'b0;
        enable      = 1'b1;
        in_valid    = 1'b0;
        in_value    = 6'd0;
        in_negative = 1'b0;
        in_is_dec   = 1'b0;

        $display("[TB] reset and free-running scan");
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 50);

        $display("[TB] single update committed at frame end");
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd42, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 45);

        $display("[TB] offer on frame_done cycle");
        waitForPos(FRAME_LEN - 1, "wait_frame_done");
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd17, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 30);

        $display("[TB] held valid while pending");
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd63, 1'b1, 1'b0, 60);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 30);

        $display("[TB] enable drop in slot 2 dwell");
        waitForPos(2 * SLOT_LEN + BL + 1, "wait_slot2_dwell");
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd21, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 30);

        $display("[TB] reset with pending data");
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd33, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 5);
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 30);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 199) != 0,
                          $urandom_range(0, 39) != 0,
                          $urandom_range(0, 3) == 0,
                          6'($urandom),
                          1'($urandom),
                          1'($urandom),
                          1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 2);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
